// File: rtl/mem_copy_engine.sv
// ----------------------------------------------------------------------------
// mem_copy_engine
// Word-copy master placed in front of a single-port data memory with a
// combinational read path. After a start request it copies `length`
// consecutive words from src_addr to dst_addr, one READ/WRITE cycle pair per
// word in strictly ascending order, and then pulses done for one cycle.
// A request whose source or destination range runs past MEM_DEPTH is
// rejected up front: done pulses with error=1 and no write is ever issued.
//
// Ports
//   clk, reset                  clock, asynchronous active-high reset
//   start                       request pulse, only honoured while idle
//   src_addr, dst_addr, length  request fields, captured when start is accepted
//   busy                        high in every state except idle
//   done                        one-cycle completion pulse
//   error                       range fault of the last accepted request
//   mem_address                 memory address
//   mem_write_data              memory write data
//   mem_write_enable            memory write strobe
//   mem_read_data               combinational memory read data
// All outputs come straight from flops.
// ----------------------------------------------------------------------------
module mem_copy_engine #(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int MEM_DEPTH = 85,
   parameter int LEN_W     = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] src_addr,
   input  logic [ADDR_W-1:0] dst_addr,
   input  logic [LEN_W-1:0]  length,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_write_data,
   output logic              mem_write_enable,
   input  logic [DATA_W-1:0] mem_read_data
);

   // End addresses are formed one bit wider than addr+len so they can never wrap.
   localparam int                SUM_W     = ADDR_W + LEN_W + 1;
   localparam logic [SUM_W-1:0]  DEPTH_LIM = SUM_W'(MEM_DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_WRITE = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t            state_r, state_s;
   logic [ADDR_W-1:0] src_ptr_r, src_ptr_s;
   logic [ADDR_W-1:0] dst_ptr_r, dst_ptr_s;
   logic [LEN_W-1:0]  count_r, count_s;
   logic [DATA_W-1:0] buf_r, buf_s;
   logic              error_r, error_s;
   logic              busy_r, done_r, we_r;
   logic [ADDR_W-1:0] addr_r, addr_s;
   logic [DATA_W-1:0] wdata_r, wdata_s;
   logic [SUM_W-1:0]  src_end_s, dst_end_s;
   logic              fault_s;

   assign src_end_s = SUM_W'(src_addr) + SUM_W'(length);
   assign dst_end_s = SUM_W'(dst_addr) + SUM_W'(length);
   assign fault_s   = (length != {LEN_W{1'b0}}) &&
                      ((src_end_s > DEPTH_LIM) || (dst_end_s > DEPTH_LIM));

   // Next-state, datapath and look-ahead output values.
   always_comb begin
      state_s   = state_r;
      src_ptr_s = src_ptr_r;
      dst_ptr_s = dst_ptr_r;
      count_s   = count_r;
      buf_s     = buf_r;
      error_s   = error_r;
      addr_s    = addr_r;
      wdata_s   = wdata_r;

      case (state_r)
         ST_IDLE: begin
            if (start) begin
               src_ptr_s = src_addr;
               dst_ptr_s = dst_addr;
               count_s   = length;
               if (fault_s) begin
                  state_s = ST_DONE;
                  error_s = 1'b1;
               end else if (length == {LEN_W{1'b0}}) begin
                  state_s = ST_DONE;
                  error_s = 1'b0;
               end else begin
                  state_s = ST_READ;
                  error_s = 1'b0;
               end
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_READ: begin
            buf_s   = mem_read_data;
            state_s = ST_WRITE;
         end
         ST_WRITE: begin
            src_ptr_s = src_ptr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
            dst_ptr_s = dst_ptr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
            count_s   = count_r - {{(LEN_W-1){1'b0}}, 1'b1};
            if (count_r == {{(LEN_W-1){1'b0}}, 1'b1}) begin
               state_s = ST_DONE;
            end else begin
               state_s = ST_READ;
            end
         end
         ST_DONE: begin
            state_s = ST_IDLE;
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase

      // Memory pins are computed for the state being entered so that they
      // can be registered and still line up with that state.
      case (state_s)
         ST_READ: begin
            addr_s = src_ptr_s;
         end
         ST_WRITE: begin
            addr_s  = dst_ptr_s;
            wdata_s = buf_s;
         end
         default: begin
            addr_s  = addr_r;
            wdata_s = wdata_r;
         end
      endcase
   end

   // State, datapath and registered output flops.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r   <= ST_IDLE;
         src_ptr_r <= {ADDR_W{1'b0}};
         dst_ptr_r <= {ADDR_W{1'b0}};
         count_r   <= {LEN_W{1'b0}};
         buf_r     <= {DATA_W{1'b0}};
         error_r   <= 1'b0;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
         we_r      <= 1'b0;
         addr_r    <= {ADDR_W{1'b0}};
         wdata_r   <= {DATA_W{1'b0}};
      end else begin
         state_r   <= state_s;
         src_ptr_r <= src_ptr_s;
         dst_ptr_r <= dst_ptr_s;
         count_r   <= count_s;
         buf_r     <= buf_s;
         error_r   <= error_s;
         busy_r    <= (state_s != ST_IDLE);
         done_r    <= (state_s == ST_DONE);
         we_r      <= (state_s == ST_WRITE);
         addr_r    <= addr_s;
         wdata_r   <= wdata_s;
      end
   end

   assign busy             = busy_r;
   assign done             = done_r;
   assign error            = error_r;
   assign mem_address      = addr_r;
   assign mem_write_data   = wdata_r;
   assign mem_write_enable = we_r;

endmodule

// File: tb/tb_mem_copy_engine.sv
// ----------------------------------------------------------------------------
// tb_mem_copy_engine
// Bench for mem_copy_engine. A behavioural 85-word memory is attached to the
// DUT; a separate reference array is updated by plain array copies taken from
// the request rules, and the two are compared after each transfer together
// with done timing, write-pulse counts and the error flag.
// ----------------------------------------------------------------------------
module tb_mem_copy_engine;

   localparam int DEPTH = 85;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [31:0] src_addr, dst_addr;
   logic [7:0]  length;
   logic        busy, done, error;
   logic [31:0] mem_address, mem_write_data, mem_read_data;
   logic        mem_write_enable;

   int checks = 0;
   int errors = 0;

   logic [31:0] mem     [DEPTH];
   logic [31:0] seed    [DEPTH];
   logic [31:0] ref_mem [DEPTH];
   logic        load = 1'b0;
   int          wr_cnt = 0;

   // observations collected by run_copy
   int obs_done_cyc, obs_ndone, obs_writes, obs_busy_bad, obs_mem_bad, obs_first_bad;
   logic obs_err, obs_err_end, obs_busy_end;

   mem_copy_engine dut (
      .clk(clk), .reset(reset), .start(start),
      .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
      .busy(busy), .done(done), .error(error),
      .mem_address(mem_address), .mem_write_data(mem_write_data),
      .mem_write_enable(mem_write_enable), .mem_read_data(mem_read_data)
   );

   always #5 clk = ~clk;

   // behavioural memory: preload port plus the DUT write port
   always @(posedge clk) begin
      if (load) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= seed[i];
      end else if (mem_write_enable) begin
         if (mem_address < 32'd85) mem[mem_address[6:0]] <= mem_write_data;
         wr_cnt <= wr_cnt + 1;
      end
   end

   assign mem_read_data = (mem_address < 32'd85) ? mem[mem_address[6:0]] : 32'd0;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic load_mem();
      for (int i = 0; i < DEPTH; i++) begin
         seed[i]    = $urandom;
         ref_mem[i] = seed[i];
      end
      @(negedge clk); load = 1'b1;
      @(negedge clk); load = 1'b0;
   endtask

   // Reference: reject out-of-range requests, otherwise copy word by word ascending.
   task automatic ref_copy(input logic [31:0] s, input logic [31:0] d, input int n,
                           output bit fault);
      longint se, de;
      se = longint'(s) + n;
      de = longint'(d) + n;
      fault = (n != 0) && (se > DEPTH || de > DEPTH);
      if (!fault) begin
         for (int i = 0; i < n; i++) ref_mem[int'(d) + i] = ref_mem[int'(s) + i];
      end
   endtask

   task automatic cmp_mem();
      obs_mem_bad = 0; obs_first_bad = -1;
      for (int i = 0; i < DEPTH; i++) begin
         if (mem[i] !== ref_mem[i]) begin
            if (obs_mem_bad == 0) obs_first_bad = i;
            obs_mem_bad++;
         end
      end
   endtask

   // Drive one request and record what happens over a bounded window.
   task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input logic [7:0] n,
                           input int glitch_at, input bit start_in_done);
      int w0, limit;
      limit = 2 * int'(n) + 6;
      w0 = wr_cnt;
      obs_done_cyc = 0; obs_ndone = 0; obs_busy_bad = 0; obs_err = 1'b0;
      @(negedge clk);
      src_addr = s; dst_addr = d; length = n; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      for (int cyc = 1; cyc <= limit; cyc++) begin
         if (done === 1'b1) begin
            obs_ndone++;
            if (obs_done_cyc == 0) begin
               obs_done_cyc = cyc;
               obs_err      = error;
               if (start_in_done) begin
                  start = 1'b1; src_addr = 32'd2; dst_addr = 32'd70; length = 8'd3;
               end
            end
         end else if (obs_done_cyc == 0 && busy !== 1'b1) begin
            obs_busy_bad++;
         end
         if (cyc == glitch_at) begin
            start = 1'b1; src_addr = 32'd5; dst_addr = 32'd60; length = 8'd2;
         end
         @(posedge clk); #1; start = 1'b0;
      end
      obs_writes   = wr_cnt - w0;
      obs_busy_end = busy;
      obs_err_end  = error;
      cmp_mem();
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; src_addr = 32'd0; dst_addr = 32'd0; length = 8'd0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if ({busy, done, error, mem_write_enable} !== 4'b0000) begin errors++;
         $display("FAIL reset_flags: got %b expected 0000", {busy, done, error, mem_write_enable}); end
      checks++; if (mem_address !== 32'd0) begin errors++;
         $display("FAIL reset_addr: got %h expected 0", mem_address); end
      checks++; if (mem_write_data !== 32'd0) begin errors++;
         $display("FAIL reset_wdata: got %h expected 0", mem_write_data); end
      @(negedge clk); reset = 1'b0;
   endtask

   task automatic test_basic_copy();
      bit f;
      load_mem();
      ref_copy(32'd0, 32'd40, 4, f);
      run_copy(32'd0, 32'd40, 8'd4, 0, 1'b0);
      checks++; if (obs_done_cyc != 9) begin errors++;
         $display("FAIL basic_done_cycle: got %0d expected 9", obs_done_cyc); end
      checks++; if (obs_ndone != 1) begin errors++;
         $display("FAIL basic_done_count: got %0d expected 1", obs_ndone); end
      checks++; if (obs_writes != 4) begin errors++;
         $display("FAIL basic_writes: got %0d expected 4", obs_writes); end
      checks++; if (obs_err !== 1'b0) begin errors++;
         $display("FAIL basic_error: got %b expected 0", obs_err); end
      checks++; if (obs_busy_bad != 0) begin errors++;
         $display("FAIL basic_busy: got %0d low cycles expected 0", obs_busy_bad); end
      checks++; if (obs_mem_bad != 0) begin errors++;
         $display("FAIL basic_mem: got %0d bad words (first %0d) expected 0", obs_mem_bad, obs_first_bad); end
      checks++; if (obs_busy_end !== 1'b0) begin errors++;
         $display("FAIL basic_idle: got busy=%b expected 0", obs_busy_end); end
   endtask

   task automatic test_zero_len();
      bit f;
      ref_copy(32'd3, 32'd30, 0, f);
      run_copy(32'd3, 32'd30, 8'd0, 0, 1'b0);
      checks++; if (obs_done_cyc != 1) begin errors++;
         $display("FAIL zero_done_cycle: got %0d expected 1", obs_done_cyc); end
      checks++; if (obs_writes != 0 || obs_err !== 1'b0) begin errors++;
         $display("FAIL zero_writes_error: got %0d/%b expected 0/0", obs_writes, obs_err); end
      checks++; if (obs_mem_bad != 0) begin errors++;
         $display("FAIL zero_mem: got %0d bad words expected 0", obs_mem_bad); end
   endtask

   task automatic test_fault();
      bit f;
      logic [31:0] s_tab [3] = '{32'd80, 32'hFFFF_FFFE, 32'd10};
      logic [31:0] d_tab [3] = '{32'd0,  32'd0,         32'd84};
      logic [7:0]  n_tab [3] = '{8'd6,   8'd4,          8'd2};
      for (int k = 0; k < 3; k++) begin
         ref_copy(s_tab[k], d_tab[k], int'(n_tab[k]), f);
         run_copy(s_tab[k], d_tab[k], n_tab[k], 0, 1'b0);
         checks++; if (obs_done_cyc != 1 || obs_err !== 1'b1) begin errors++;
            $display("FAIL fault_%0d_done_err: got cyc %0d err %b expected cyc 1 err 1", k, obs_done_cyc, obs_err); end
         checks++; if (obs_writes != 0 || obs_mem_bad != 0) begin errors++;
            $display("FAIL fault_%0d_nowrite: got %0d writes %0d bad words expected 0/0", k, obs_writes, obs_mem_bad); end
         checks++; if (obs_err_end !== 1'b1) begin errors++;
            $display("FAIL fault_%0d_hold: got error=%b expected 1", k, obs_err_end); end
      end
      // range ending exactly at MEM_DEPTH is legal and clears error
      ref_copy(32'd81, 32'd20, 4, f);
      run_copy(32'd81, 32'd20, 8'd4, 0, 1'b0);
      checks++; if (obs_done_cyc != 9 || obs_err !== 1'b0 || obs_err_end !== 1'b0) begin errors++;
         $display("FAIL fault_clear: got cyc %0d err %b/%b expected 9 0/0", obs_done_cyc, obs_err, obs_err_end); end
      checks++; if (obs_writes != 4 || obs_mem_bad != 0) begin errors++;
         $display("FAIL fault_clear_mem: got %0d writes %0d bad expected 4/0", obs_writes, obs_mem_bad); end
   endtask

   task automatic test_overlap();
      bit f;
      load_mem();
      ref_copy(32'd10, 32'd11, 3, f);
      run_copy(32'd10, 32'd11, 8'd3, 0, 1'b0);
      for (int i = 11; i <= 13; i++) begin
         checks++; if (mem[i] !== seed[10]) begin errors++;
            $display("FAIL overlap_word%0d: got %h expected %h", i, mem[i], seed[10]); end
      end
      checks++; if (obs_writes != 3 || obs_mem_bad != 0 || obs_done_cyc != 7) begin errors++;
         $display("FAIL overlap_summary: got %0d writes %0d bad cyc %0d expected 3/0/7", obs_writes, obs_mem_bad, obs_done_cyc); end
   endtask

   task automatic test_back_to_back();
      bit f;
      load_mem();
      ref_copy(32'd0, 32'd40, 4, f);
      run_copy(32'd0, 32'd40, 8'd4, 3, 1'b1);
      checks++; if (obs_ndone != 1 || obs_done_cyc != 9) begin errors++;
         $display("FAIL busy_start_done: got %0d pulses at %0d expected 1 at 9", obs_ndone, obs_done_cyc); end
      checks++; if (obs_writes != 4 || obs_mem_bad != 0) begin errors++;
         $display("FAIL busy_start_mem: got %0d writes %0d bad expected 4/0", obs_writes, obs_mem_bad); end
      checks++; if (obs_busy_end !== 1'b0) begin errors++;
         $display("FAIL busy_start_idle: got busy=%b expected 0", obs_busy_end); end
   endtask

   task automatic test_reset_mid_copy();
      int w0, nd;
      load_mem();
      ref_mem[50] = ref_mem[20];          // only the first word lands
      w0 = wr_cnt;
      @(negedge clk);
      src_addr = 32'd20; dst_addr = 32'd50; length = 8'd5; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      checks++; if (mem_write_enable !== 1'b1 || mem_address !== 32'd51) begin errors++;
         $display("FAIL rst_mid_prewrite: got we=%b addr=%0d expected 1/51", mem_write_enable, mem_address); end
      reset = 1'b1;
      #1;
      checks++; if (mem_write_enable !== 1'b0 || busy !== 1'b0) begin errors++;
         $display("FAIL rst_mid_async: got we=%b busy=%b expected 0/0", mem_write_enable, busy); end
      nd = 0;
      repeat (4) begin @(posedge clk); #1; if (done === 1'b1) nd++; end
      @(negedge clk); reset = 1'b0;
      repeat (3) begin @(posedge clk); #1; if (done === 1'b1) nd++; end
      checks++; if (nd != 0) begin errors++;
         $display("FAIL rst_mid_done: got %0d pulses expected 0", nd); end
      cmp_mem();
      checks++; if (wr_cnt - w0 != 1 || obs_mem_bad != 0) begin errors++;
         $display("FAIL rst_mid_mem: got %0d writes %0d bad (first %0d) expected 1/0", wr_cnt - w0, obs_mem_bad, obs_first_bad); end
   endtask

   task automatic test_random();
      bit f;
      logic [31:0] s, d;
      logic [7:0]  n;
      int exp_cyc, exp_wr;
      load_mem();
      for (int k = 0; k < 12; k++) begin
         s = $urandom_range(90, 0);
         d = $urandom_range(90, 0);
         n = 8'($urandom_range(12, 0));
         ref_copy(s, d, int'(n), f);
         exp_cyc = (f || n == 8'd0) ? 1 : 2 * int'(n) + 1;
         exp_wr  = f ? 0 : int'(n);
         run_copy(s, d, n, 0, 1'b0);
         checks++;
         if (obs_done_cyc != exp_cyc || obs_ndone != 1 || obs_err !== logic'(f) ||
             obs_writes != exp_wr || obs_mem_bad != 0) begin
            errors++;
            $display("FAIL rand_%0d src=%0d dst=%0d len=%0d: got cyc %0d pulses %0d err %b wr %0d bad %0d expected cyc %0d pulses 1 err %b wr %0d bad 0",
                     k, s, d, n, obs_done_cyc, obs_ndone, obs_err, obs_writes, obs_mem_bad, exp_cyc, f, exp_wr);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic_copy();
      test_zero_len();
      test_fault();
      test_overlap();
      test_back_to_back();
      test_reset_mid_copy();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
